// File: rtl/mouse_packet_decoder_pkg.sv
// Shared definitions for the PS/2 mouse packet decoder: FSM encoding,
// status-byte bit positions and the delta-forming helper.
package mouse_packet_decoder_pkg;

  typedef enum logic [1:0] {
    WAIT_B0 = 2'd0,
    WAIT_B1 = 2'd1,
    WAIT_B2 = 2'd2,
    UPDATE  = 2'd3
  } state_e;

  localparam int SYNC_BIT  = 3;
  localparam int XSIGN_BIT = 4;
  localparam int YSIGN_BIT = 5;
  localparam int XOVF_BIT  = 6;
  localparam int YOVF_BIT  = 7;

  // An overflowed axis saturates to the extreme of its sign.
  function automatic logic [8:0] make_delta(input logic sign, input logic ovf,
                                            input logic [7:0] low);
    if (ovf) return sign ? 9'h100 : 9'h0FF;
    return {sign, low};
  endfunction

endpackage

// File: rtl/mouse_axis_accum.sv
// One screen axis: adds (or subtracts) a signed 9-bit delta and clamps the
// result to [0, MAX]; passes the current position through unless loading.
module mouse_axis_accum
  import mouse_packet_decoder_pkg::*;
#(
  parameter int MAX   = 159,
  parameter int POS_W = 8
) (
  input  logic [POS_W-1:0] pos,
  input  logic [8:0]       delta,
  input  logic             negate,
  input  logic             load,
  output logic [POS_W-1:0] pos_next
);

  localparam int AW = POS_W + 3;
  localparam logic signed [AW-1:0] MAX_S = AW'(MAX);

  logic signed [AW-1:0] dext;
  logic signed [AW-1:0] sum;

  always_comb begin
    dext = AW'($signed(delta));
    if (negate) dext = -dext;
    sum = $signed({3'b000, pos}) + dext;
    pos_next = pos;
    if (load) begin
      if (sum < 0)          pos_next = '0;
      else if (sum > MAX_S) pos_next = POS_W'(MAX);
      else                  pos_next = sum[POS_W-1:0];
    end
  end

endmodule

// File: rtl/mouse_packet_decoder.sv
// Assembles 3-byte PS/2 mouse packets, rejects errored/misaligned bytes and
// tracks a clamped screen position with a one-cycle PACKET_VALID strobe.
module mouse_packet_decoder
  import mouse_packet_decoder_pkg::*;
#(
  parameter int MAX_X         = 159,
  parameter int MAX_Y         = 119,
  parameter int POS_W         = 8,
  parameter int T_PKT_TIMEOUT = 100000
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             ENABLE,
  input  logic [7:0]       BYTE_READ,
  input  logic [1:0]       BYTE_ERROR_CODE,
  input  logic             BYTE_READY,
  output logic             READ_ENABLE,
  output logic [7:0]       MOUSE_STATUS,
  output logic [8:0]       MOUSE_DX,
  output logic [8:0]       MOUSE_DY,
  output logic [POS_W-1:0] MOUSE_X,
  output logic [POS_W-1:0] MOUSE_Y,
  output logic             PACKET_VALID,
  output logic [7:0]       PACKET_ERR_CNT
);

  localparam int TW = $clog2(T_PKT_TIMEOUT + 1);
  localparam logic [TW-1:0] T_LIM = TW'(T_PKT_TIMEOUT);

  state_e           state_q, state_d;
  logic [7:0]       b0_q, b0_d, b1_q, b1_d, status_q, status_d, err_q, err_d;
  logic [8:0]       dx_q, dx_d, dy_q, dy_d;
  logic [POS_W-1:0] x_q, x_d, y_q, y_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic             pv_q, pv_d, err_inc, load, clean;

  always_comb begin
    state_d  = state_q;
    b0_d     = b0_q;
    b1_d     = b1_q;
    status_d = status_q;
    dx_d     = dx_q;
    dy_d     = dy_q;
    timer_d  = '0;
    pv_d     = 1'b0;
    load     = 1'b0;
    err_inc  = 1'b0;
    clean    = (BYTE_ERROR_CODE == 2'b00);
    if (!ENABLE) begin
      state_d = WAIT_B0;
    end else begin
      case (state_q)
        WAIT_B0: if (BYTE_READY) begin
          if (clean && BYTE_READ[SYNC_BIT]) begin
            b0_d    = BYTE_READ;
            state_d = WAIT_B1;
          end else err_inc = 1'b1;
        end
        WAIT_B1, WAIT_B2: begin
          if (BYTE_READY) begin
            if (!clean) begin
              err_inc = 1'b1;
              state_d = WAIT_B0;
            end else if (state_q == WAIT_B1) begin
              b1_d    = BYTE_READ;
              state_d = WAIT_B2;
            end else begin
              status_d = b0_q;
              dx_d     = make_delta(b0_q[XSIGN_BIT], b0_q[XOVF_BIT], b1_q);
              dy_d     = make_delta(b0_q[YSIGN_BIT], b0_q[YOVF_BIT], BYTE_READ);
              state_d  = UPDATE;
            end
          end else if (timer_q == T_LIM) begin
            err_inc = 1'b1;
            state_d = WAIT_B0;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        UPDATE: begin
          load    = 1'b1;
          pv_d    = 1'b1;
          state_d = WAIT_B0;
        end
        default: state_d = WAIT_B0;
      endcase
    end
    err_d = (err_inc && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
  end

  mouse_axis_accum #(.MAX(MAX_X), .POS_W(POS_W)) u_x (
    .pos(x_q), .delta(dx_q), .negate(1'b0), .load(load), .pos_next(x_d)
  );
  // Screen Y grows downward while mouse dy is positive-up, hence negate.
  mouse_axis_accum #(.MAX(MAX_Y), .POS_W(POS_W)) u_y (
    .pos(y_q), .delta(dy_q), .negate(1'b1), .load(load), .pos_next(y_d)
  );

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q  <= WAIT_B0;
      b0_q     <= '0;
      b1_q     <= '0;
      status_q <= '0;
      dx_q     <= '0;
      dy_q     <= '0;
      x_q      <= POS_W'(MAX_X >> 1);
      y_q      <= POS_W'(MAX_Y >> 1);
      timer_q  <= '0;
      pv_q     <= 1'b0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      b0_q     <= b0_d;
      b1_q     <= b1_d;
      status_q <= status_d;
      dx_q     <= dx_d;
      dy_q     <= dy_d;
      x_q      <= x_d;
      y_q      <= y_d;
      timer_q  <= timer_d;
      pv_q     <= pv_d;
      err_q    <= err_d;
    end
  end

  assign READ_ENABLE    = ENABLE & (state_q != UPDATE);
  assign MOUSE_STATUS   = status_q;
  assign MOUSE_DX       = dx_q;
  assign MOUSE_DY       = dy_q;
  assign MOUSE_X        = x_q;
  assign MOUSE_Y        = y_q;
  assign PACKET_VALID   = pv_q;
  assign PACKET_ERR_CNT = err_q;

endmodule

// File: tb/tb_mouse_packet_decoder.sv
// Directed bench for mouse_packet_decoder: a packet-level model (byte queue,
// integer clamp arithmetic) checked against the DUT every cycle, plus literals.
module tb_mouse_packet_decoder;

  localparam int MAX_X = 159;
  localparam int MAX_Y = 119;
  localparam int POS_W = 8;
  localparam int T     = 40;

  logic             CLK, RESET_N, ENABLE, BYTE_READY;
  logic [7:0]       BYTE_READ;
  logic [1:0]       BYTE_ERROR_CODE;
  logic             READ_ENABLE, PACKET_VALID;
  logic [7:0]       MOUSE_STATUS, PACKET_ERR_CNT;
  logic [8:0]       MOUSE_DX, MOUSE_DY;
  logic [POS_W-1:0] MOUSE_X, MOUSE_Y;

  mouse_packet_decoder #(.MAX_X(MAX_X), .MAX_Y(MAX_Y), .POS_W(POS_W),
                         .T_PKT_TIMEOUT(T)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .ENABLE(ENABLE), .BYTE_READ(BYTE_READ),
    .BYTE_ERROR_CODE(BYTE_ERROR_CODE), .BYTE_READY(BYTE_READY),
    .READ_ENABLE(READ_ENABLE), .MOUSE_STATUS(MOUSE_STATUS), .MOUSE_DX(MOUSE_DX),
    .MOUSE_DY(MOUSE_DY), .MOUSE_X(MOUSE_X), .MOUSE_Y(MOUSE_Y),
    .PACKET_VALID(PACKET_VALID), .PACKET_ERR_CNT(PACKET_ERR_CNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_vec = 0, n_bad = 0;
  bit chk_on = 0;

  // Model state: expected outputs plus the partially collected packet.
  int e_status, e_dx, e_dy, e_x, e_y, e_err, e_pv, e_re;
  logic [7:0] pkt[$];
  int idle_cnt;

  task automatic cmp(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int delta(input logic sign, input logic ovf, input logic [7:0] low);
    if (ovf) return sign ? -256 : 255;
    return sign ? int'(low) - 256 : int'(low);
  endfunction

  function automatic int clamp(input int v, input int hi);
    return (v < 0) ? 0 : (v > hi) ? hi : v;
  endfunction

  function automatic void bump_err();
    if (e_err < 255) e_err++;
  endfunction

  function automatic void model_reset();
    e_status = 0; e_dx = 0; e_dy = 0; e_pv = 0; e_err = 0;
    e_x = MAX_X / 2; e_y = MAX_Y / 2; e_re = int'(ENABLE);
    pkt.delete(); idle_cnt = 0;
  endfunction

  // A clock edge with no byte offered.
  function automatic void model_idle();
    if (pkt.size() > 0) begin
      idle_cnt++;
      if (idle_cnt == T + 1) begin
        pkt.delete();
        bump_err();
      end
    end
  endfunction

  // A clock edge that sampled a byte; returns 1 when a packet completed.
  function automatic bit model_byte(input logic [7:0] b, input logic [1:0] ec);
    logic [7:0] s;
    idle_cnt = 0;
    if (pkt.size() == 0) begin
      if (ec == 0 && b[3]) pkt.push_back(b);
      else bump_err();
      return 0;
    end
    if (ec != 0) begin
      pkt.delete();
      bump_err();
      return 0;
    end
    pkt.push_back(b);
    if (pkt.size() < 3) return 0;
    s = pkt[0];
    e_status = int'(s);
    e_dx = delta(s[4], s[6], pkt[1]);
    e_dy = delta(s[5], s[7], pkt[2]);
    pkt.delete();
    e_re = 0;
    return 1;
  endfunction

  always @(negedge CLK) if (chk_on) begin
    cmp("read_enable", int'(READ_ENABLE), e_re);
    cmp("status", int'(MOUSE_STATUS), e_status);
    cmp("dx", int'($signed(MOUSE_DX)), e_dx);
    cmp("dy", int'($signed(MOUSE_DY)), e_dy);
    cmp("x", int'(MOUSE_X), e_x);
    cmp("y", int'(MOUSE_Y), e_y);
    cmp("packet_valid", int'(PACKET_VALID), e_pv);
    cmp("err_cnt", int'(PACKET_ERR_CNT), e_err);
  end

  task automatic do_reset();
    @(posedge CLK); #2;
    RESET_N = 1'b0;
    model_reset();
    chk_on = 1;
    repeat (2) @(posedge CLK);
    #2 RESET_N = 1'b1;
  endtask

  task automatic send(input logic [7:0] b, input logic [1:0] ec);
    bit done;
    @(posedge CLK); model_idle(); #2;
    BYTE_READ = b; BYTE_ERROR_CODE = ec; BYTE_READY = 1'b1;
    @(posedge CLK); #2;
    BYTE_READY = 1'b0; BYTE_ERROR_CODE = 2'b00;
    done = model_byte(b, ec);
    if (done) begin
      @(posedge CLK); #2;
      e_x = clamp(e_x + e_dx, MAX_X);
      e_y = clamp(e_y - e_dy, MAX_Y);
      e_pv = 1; e_re = int'(ENABLE);
      @(posedge CLK); #2;
      e_pv = 0;
    end
  endtask

  task automatic pkt3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    send(a, 2'b00); send(b, 2'b00); send(c, 2'b00);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge CLK); model_idle(); end
    #2;
  endtask

  task automatic set_enable(input logic v);
    @(posedge CLK); model_idle(); #2;
    ENABLE = v; e_re = int'(v);
    @(posedge CLK);
    if (!v) begin pkt.delete(); idle_cnt = 0; end
    else model_idle();
    #2;
  endtask

  initial begin
    RESET_N = 1'b0; ENABLE = 1'b1; BYTE_READY = 1'b0;
    BYTE_READ = 8'h00; BYTE_ERROR_CODE = 2'b00;
    do_reset();
    cmp("lit_reset_x", int'(MOUSE_X), 79);
    cmp("lit_reset_y", int'(MOUSE_Y), 59);

    // 1: basic packet
    pkt3(8'h08, 8'h05, 8'h03);
    cmp("lit_t1_dx", int'($signed(MOUSE_DX)), 5);
    cmp("lit_t1_dy", int'($signed(MOUSE_DY)), 3);
    cmp("lit_t1_x", int'(MOUSE_X), 84);
    cmp("lit_t1_y", int'(MOUSE_Y), 56);

    // 2: negative dx and clamp at zero
    do_reset();
    pkt3(8'h18, 8'hF6, 8'h00);
    cmp("lit_t2_dx", int'($signed(MOUSE_DX)), -10);
    cmp("lit_t2_x", int'(MOUSE_X), 69);
    repeat (5) pkt3(8'h18, 8'hB0, 8'h00);
    cmp("lit_t2_xclamp", int'(MOUSE_X), 0);

    // 3: sync bit missing on first byte
    do_reset();
    send(8'h00, 2'b00);
    cmp("lit_t3_err", int'(PACKET_ERR_CNT), 1);
    pkt3(8'h08, 8'h01, 8'h01);
    cmp("lit_t3_x", int'(MOUSE_X), 80);
    cmp("lit_t3_y", int'(MOUSE_Y), 58);

    // 4: parity error mid-packet, then stop-bit error on byte 2
    send(8'h08, 2'b00); send(8'h07, 2'b01);
    cmp("lit_t4_err", int'(PACKET_ERR_CNT), 2);
    send(8'h08, 2'b00); send(8'h01, 2'b00); send(8'h09, 2'b10);
    idle(3);

    // 5: inter-byte timeout then clean realignment
    send(8'h08, 2'b00); send(8'h05, 2'b00);
    idle(T + 5);
    cmp("lit_t5_err", int'(PACKET_ERR_CNT), 4);
    pkt3(8'h08, 8'h02, 8'h00);
    cmp("lit_t5_dx", int'($signed(MOUSE_DX)), 2);
    // byte arriving right at the timeout boundary still counts
    send(8'h08, 2'b00);
    idle(T - 1);
    send(8'h03, 2'b00); send(8'h00, 2'b00);

    // 6: overflow, Y overflow negative, ENABLE drop mid-packet
    pkt3(8'h48, 8'h00, 8'h00);
    cmp("lit_t6_dx", int'($signed(MOUSE_DX)), 255);
    cmp("lit_t6_x", int'(MOUSE_X), 159);
    pkt3(8'hA8, 8'h00, 8'h00);
    cmp("lit_t6_dy", int'($signed(MOUSE_DY)), -256);
    cmp("lit_t6_y", int'(MOUSE_Y), 119);
    send(8'h08, 2'b00); send(8'h05, 2'b00);
    set_enable(1'b0);
    idle(3);
    set_enable(1'b1);
    cmp("lit_t6_err", int'(PACKET_ERR_CNT), 4);
    pkt3(8'h38, 8'hFF, 8'hFF);

    // error counter saturation
    repeat (260) send(8'h00, 2'b00);
    cmp("lit_err_sat", int'(PACKET_ERR_CNT), 255);
    idle(2);

    chk_on = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
